// File: rtl/ctech_lib_handshake_sync_rx.sv
// Receive side of a 4-phase req/ack clock-domain crossing: synchronises req_a, captures data_a once per
// request and presents it on a valid/ready interface; ack, o_valid and busy come straight off one-hot state flops.
module ctech_lib_handshake_sync_rx #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  output logic             ack,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             busy,
  output logic             err
);

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    VALID = 3'b010,
    ACK   = 3'b100
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  logic [WIDTH-1:0]       data_q, data_d;
  logic                   err_q, err_d;

  // req_a is only ever seen through this chain; data_a is trusted stable once req_s is high.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req_a};
    end
  end

  assign req_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_s) begin
          data_d  = data_a;
          state_d = VALID;
        end
      end
      VALID: begin
        // A withdrawn request is flagged but the captured word is still delivered.
        if (!req_s) begin
          err_d = 1'b1;
        end
        if (o_ready) begin
          state_d = req_s ? ACK : IDLE;
        end
      end
      ACK: begin
        if (!req_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy    = ~state_q[0];
  assign o_valid = state_q[1];
  assign ack     = state_q[2];
  assign o_data  = data_q;
  assign err     = err_q;

endmodule

// File: tb/tb_ctech_lib_handshake_sync_rx.sv
// Directed 4-phase scenarios on a 2-stage instance and a randomised sender/consumer scoreboard on a 3-stage instance.
module tb_ctech_lib_handshake_sync_rx;

  logic       clk;
  logic       rstb;
  logic       req2, rdy2, ack2, vld2, busy2, err2;
  logic [7:0] dat2, odat2;
  logic       req3, rdy3, ack3, vld3, busy3, err3;
  logic [7:0] dat3, odat3;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] exp_q[$];
  int         recv;

  ctech_lib_handshake_sync_rx #(.WIDTH(8), .SYNC_STAGES(2)) dut2 (
    .clk(clk), .rstb(rstb), .req_a(req2), .data_a(dat2), .ack(ack2),
    .o_valid(vld2), .o_ready(rdy2), .o_data(odat2), .busy(busy2), .err(err2)
  );

  ctech_lib_handshake_sync_rx #(.WIDTH(8), .SYNC_STAGES(3)) dut3 (
    .clk(clk), .rstb(rstb), .req_a(req3), .data_a(dat3), .ack(ack3),
    .o_valid(vld3), .o_ready(rdy3), .o_data(odat3), .busy(busy3), .err(err3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    req2 = 1'b0; rdy2 = 1'b0; dat2 = 8'h00;
    req3 = 1'b0; rdy3 = 1'b0; dat3 = 8'h00;
    tick();
    tick();
    n_cmp++;
    if ({ack2, vld2, busy2, err2, odat2} !== 12'h000) begin
      n_fail++; $display("FAIL reset_dut2: got ack/vld/busy/err/data=%b%b%b%b/%h want 0000/00", ack2, vld2, busy2, err2, odat2);
    end
    n_cmp++;
    if ({ack3, vld3, busy3, err3, odat3} !== 12'h000) begin
      n_fail++; $display("FAIL reset_dut3: got ack/vld/busy/err/data=%b%b%b%b/%h want 0000/00", ack3, vld3, busy3, err3, odat3);
    end
    rstb = 1'b1;
    tick();
    n_cmp++;
    if ({busy2, vld2} !== 2'b00) begin
      n_fail++; $display("FAIL reset_release_idle: got busy/vld=%b%b want 00", busy2, vld2);
    end
  endtask

  // o_valid on the third edge after req_a is first sampled, ack on the fourth,
  // ack released once the 2-flop chain has carried req_a=0 through (third edge).
  task automatic test_basic();
    dat2 = 8'hA5; req2 = 1'b1; rdy2 = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (vld2 !== 1'b0) begin
      n_fail++; $display("FAIL basic_vld_edge2: got %b want 0", vld2);
    end
    tick();
    n_cmp++;
    if ({vld2, odat2, ack2, busy2} !== {1'b1, 8'hA5, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL basic_edge3: got vld=%b data=%h ack=%b busy=%b want 1 a5 0 1", vld2, odat2, ack2, busy2);
    end
    tick();
    n_cmp++;
    if ({vld2, ack2} !== 2'b01) begin
      n_fail++; $display("FAIL basic_edge4: got vld=%b ack=%b want 0 1", vld2, ack2);
    end
    req2 = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (ack2 !== 1'b1) begin
      n_fail++; $display("FAIL basic_ack_hold: got %b want 1", ack2);
    end
    tick();
    n_cmp++;
    if ({ack2, busy2} !== 2'b00) begin
      n_fail++; $display("FAIL basic_ack_release: got ack=%b busy=%b want 0 0", ack2, busy2);
    end
  endtask

  task automatic test_stall();
    dat2 = 8'h3C; req2 = 1'b1; rdy2 = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if ({vld2, odat2, ack2} !== {1'b1, 8'h3C, 1'b0}) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got vld=%b data=%h ack=%b want 1 3c 0", i, vld2, odat2, ack2);
      end
    end
    rdy2 = 1'b1;
    tick();
    n_cmp++;
    if ({vld2, ack2} !== 2'b01) begin
      n_fail++; $display("FAIL stall_accept: got vld=%b ack=%b want 0 1", vld2, ack2);
    end
    rdy2 = 1'b0;
    req2 = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({vld2, ack2, busy2} !== 3'b000) begin
      n_fail++; $display("FAIL stall_done: got vld=%b ack=%b busy=%b want 0 0 0", vld2, ack2, busy2);
    end
  endtask

  task automatic test_data_change();
    dat2 = 8'h5A; req2 = 1'b1; rdy2 = 1'b1;
    repeat (4) tick();
    n_cmp++;
    if ({ack2, odat2} !== {1'b1, 8'h5A}) begin
      n_fail++; $display("FAIL dchg_ack: got ack=%b data=%h want 1 5a", ack2, odat2);
    end
    dat2 = 8'h99;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if ({vld2, odat2, ack2} !== {1'b0, 8'h5A, 1'b1}) begin
        n_fail++; $display("FAIL dchg_hold[%0d]: got vld=%b data=%h ack=%b want 0 5a 1", i, vld2, odat2, ack2);
      end
    end
    req2 = 1'b0;
    repeat (3) tick();
    dat2 = 8'h42;
    repeat (4) tick();
    n_cmp++;
    if ({vld2, odat2, ack2} !== {1'b0, 8'h5A, 1'b0}) begin
      n_fail++; $display("FAIL dchg_idle: got vld=%b data=%h ack=%b want 0 5a 0", vld2, odat2, ack2);
    end
  endtask

  task automatic test_withdraw();
    dat2 = 8'hC3; req2 = 1'b1; rdy2 = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({vld2, err2} !== 2'b10) begin
      n_fail++; $display("FAIL wd_valid: got vld=%b err=%b want 1 0", vld2, err2);
    end
    req2 = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (err2 !== 1'b0) begin
      n_fail++; $display("FAIL wd_err_early: got %b want 0", err2);
    end
    tick();
    n_cmp++;
    if (err2 !== 1'b1) begin
      n_fail++; $display("FAIL wd_err_set: got %b want 1", err2);
    end
    repeat (3) tick();
    n_cmp++;
    if ({vld2, odat2, ack2, err2} !== {1'b1, 8'hC3, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL wd_hold: got vld=%b data=%h ack=%b err=%b want 1 c3 0 1", vld2, odat2, ack2, err2);
    end
    rdy2 = 1'b1;
    tick();
    n_cmp++;
    if ({vld2, ack2, busy2} !== 3'b000) begin
      n_fail++; $display("FAIL wd_accept: got vld=%b ack=%b busy=%b want 0 0 0", vld2, ack2, busy2);
    end
    rdy2 = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({err2, ack2, busy2} !== 3'b100) begin
      n_fail++; $display("FAIL wd_sticky: got err=%b ack=%b busy=%b want 1 0 0", err2, ack2, busy2);
    end
  endtask

  task automatic test_reset_mid_ack();
    dat2 = 8'h11; req2 = 1'b1; rdy2 = 1'b1;
    repeat (4) tick();
    n_cmp++;
    if (ack2 !== 1'b1) begin
      n_fail++; $display("FAIL rst_pre_ack: got %b want 1", ack2);
    end
    rstb = 1'b0;
    #1;
    n_cmp++;
    if ({ack2, vld2, busy2, err2, odat2} !== 12'h000) begin
      n_fail++; $display("FAIL rst_async: got ack/vld/busy/err/data=%b%b%b%b/%h want 0000/00", ack2, vld2, busy2, err2, odat2);
    end
    dat2 = 8'h77;
    tick();
    tick();
    rstb = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({vld2, ack2} !== 2'b00) begin
      n_fail++; $display("FAIL rst_no_early: got vld=%b ack=%b want 0 0", vld2, ack2);
    end
    tick();
    n_cmp++;
    if ({vld2, odat2} !== {1'b1, 8'h77}) begin
      n_fail++; $display("FAIL rst_recapture: got vld=%b data=%h want 1 77", vld2, odat2);
    end
    tick();
    n_cmp++;
    if (ack2 !== 1'b1) begin
      n_fail++; $display("FAIL rst_reack: got %b want 1", ack2);
    end
    req2 = 1'b0;
    rdy2 = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({ack2, busy2, err2} !== 3'b000) begin
      n_fail++; $display("FAIL rst_done: got ack=%b busy=%b err=%b want 0 0 0", ack2, busy2, err2);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d, e;
    int         t;
    int         guard;
    recv = 0;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          d = 8'($urandom);
          exp_q.push_back(d);
          dat3 = d;
          req3 = 1'b1;
          t = 0;
          while (ack3 !== 1'b1 && t < 300) begin tick(); t++; end
          n_cmp++;
          if (ack3 !== 1'b1) begin
            n_fail++; $display("FAIL rand_ack_rise[%0d]: got %b want 1", i, ack3);
            break;
          end
          req3 = 1'b0;
          dat3 = 8'($urandom);
          t = 0;
          while (ack3 !== 1'b0 && t < 50) begin tick(); t++; end
          n_cmp++;
          if (ack3 !== 1'b0) begin
            n_fail++; $display("FAIL rand_ack_fall[%0d]: got %b want 0", i, ack3);
            break;
          end
          repeat ($urandom_range(0, 2)) tick();
        end
        req3 = 1'b0;
      end
      begin
        guard = 0;
        while (recv < 100 && guard < 20000) begin
          rdy3 = ($urandom_range(0, 3) != 0);
          if (vld3 === 1'b1 && rdy3) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
              n_fail++; $display("FAIL rand_extra: got data=%h want no transfer", odat3);
            end else begin
              e = exp_q.pop_front();
              if (odat3 !== e) begin
                n_fail++; $display("FAIL rand_data[%0d]: got %h want %h", recv, odat3, e);
              end
            end
            recv++;
          end
          tick();
          guard++;
        end
        rdy3 = 1'b0;
      end
    join
    repeat (10) tick();
    n_cmp++;
    if (recv !== 100 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL rand_count: got %0d received, %0d pending want 100, 0", recv, exp_q.size());
    end
    n_cmp++;
    if ({err3, vld3, busy3} !== 3'b000) begin
      n_fail++; $display("FAIL rand_final: got err=%b vld=%b busy=%b want 0 0 0", err3, vld3, busy3);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_data_change();
    test_withdraw();
    test_reset_mid_ack();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ctech_lib_handshake_sync_rx.md
CTECH_LIB_HANDSHAKE_SYNC_RX -- requirements
Module: ctech_lib_handshake_sync_rx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: width of the transferred data bus, legal range 1..64.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2: number of synchronizer flops on req_a, legal values 2 or 3.
REQ-003 The block SHALL have port clk, input, 1 bit: the single receive-domain clock; all flops are rising-edge.
REQ-004 The block SHALL have port rstb, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port req_a, input, 1 bit: 4-phase request from the sender domain, asynchronous to clk.
REQ-006 The block SHALL have port data_a, input, WIDTH bits: sender data, held stable by the sender while req_a=1 and ack=0.
REQ-007 The block SHALL have port ack, output, 1 bit: 4-phase acknowledge to the sender, driven directly from a flop.
REQ-008 The block SHALL have port o_valid, output, 1 bit: captured data available to the receive-domain consumer.
REQ-009 The block SHALL have port o_ready, input, 1 bit: consumer accepts o_data on a cycle with o_valid=1 and o_ready=1.
REQ-010 The block SHALL have port o_data, output, WIDTH bits: captured data, registered.
REQ-011 The block SHALL have port busy, output, 1 bit: 1 whenever the state is not IDLE.
REQ-012 The block SHALL have port err, output, 1 bit: sticky protocol-violation flag.

Function
REQ-013 req_a SHALL pass through a SYNC_STAGES-deep flop chain, reset to 0, to produce req_s; no other logic SHALL sample req_a.
REQ-014 data_a SHALL be sampled only on the capture edge defined in REQ-016, never through a synchronizer.
REQ-015 The FSM SHALL have exactly three states: IDLE, VALID and ACK, encoded one-hot or binary.
REQ-016 IDLE: on an edge with req_s=1, the block SHALL load o_data<=data_a, set o_valid<=1 and enter VALID.
REQ-017 With SYNC_STAGES=2, o_valid SHALL rise 3 edges after the first edge that samples req_a=1.
REQ-018 VALID: o_valid and o_data SHALL hold until o_valid&o_ready; o_ready SHALL be ignored in all other states.
REQ-019 VALID, on accept with req_s=1: o_valid<=0, ack<=1, enter ACK.
REQ-020 VALID, whenever req_s=0 (req withdrawn before ack): err<=1; on accept, o_valid<=0, ack stays 0, enter IDLE.
REQ-021 ACK: ack SHALL hold 1 until an edge with req_s=0, then ack<=0 and enter IDLE.
REQ-022 ACK: req_s re-asserting is impossible; a new transfer SHALL be recognised only from IDLE.
REQ-023 Back-to-back transfers: the minimum IDLE dwell SHALL be 1 cycle; no data SHALL be captured while ack=1.
REQ-024 err SHALL be cleared only by rstb; it SHALL have no effect on FSM sequencing.
REQ-025 o_valid, ack, busy and err SHALL be glitch-free flop outputs; busy is decoded from state flops only.

Reset
REQ-026 rstb=0 SHALL asynchronously force state=IDLE, synchronizer flops=0, ack=0, o_valid=0, o_data=0, err=0, busy=0.
REQ-027 Reset mid-transfer SHALL abort it without asserting ack; if req_a is still 1 after rstb rises, it SHALL be treated as a new request after SYNC_STAGES edges.
REQ-028 Reset deassertion SHALL be synchronous to clk externally; the first active edge after rstb rises SHALL obey REQ-016.

Verification
REQ-029 Scenario: SYNC_STAGES=2, o_ready=1, req_a 0->1 with data_a=0xA5 -> o_valid=1 and o_data=0xA5 on edge 3, ack=1 on edge 4; req_a->0 -> ack=0 two edges after req_s drops, busy=0.
REQ-030 Scenario: o_ready=0 for 10 cycles after o_valid -> o_valid and o_data=0x3C stable for 10 cycles, ack=0; o_ready=1 -> accepted once, then ack=1.
REQ-031 Scenario: req_a drops while in VALID -> err=1 and sticky, ack never asserts, o_valid held until accept, then IDLE.
REQ-032 Scenario: rstb pulsed low while in ACK with req_a=1 -> all outputs 0 immediately; after release, a new capture occurs 3 edges later with the current data_a.
REQ-033 Scenario: 100 random back-to-back 4-phase transfers with random o_ready stalls and SYNC_STAGES=3 -> every value received exactly once, in order, err=0.
REQ-034 Scenario: data_a changed while ack=1 -> o_data unchanged and no second o_valid.
